// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 run-control slice: opcodes, T-state count and
// run-control state encoding.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T_STATES = 6;
    localparam int TCNT_W   = $clog2(T_STATES);
    // T-state in which the instruction register is valid for HLT decode
    localparam int HLT_TCNT = 3;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [ST_W-1:0] ST_START = 3'd2;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd3;
    localparam logic [ST_W-1:0] ST_HALT  = 3'd4;
    localparam logic [ST_W-1:0] ST_PAUSE = 3'd5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sap1_tstate_ctr.sv
// Mod-T_STATES counter with enable and synchronous clear; wrap_o pulses on the
// last enabled count so the parent can mark an instruction boundary.
module sap1_tstate_ctr #(
    parameter int T_STATES = 6,
    parameter int CNT_W    = $clog2(T_STATES)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] tcnt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_W'(T_STATES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tcnt_o = r_cnt;
    assign wrap_o = en_i && w_at_last;

endmodule

// File: rtl/sap1_run_ctrl.sv
// SAP-1 run control: loads RAM over valid/ready, releases CPU reset, runs until HLT.
// Optional single-step support is enabled by defining SAP1_STEP_EN.
module sap1_run_ctrl
    import sap1_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_start_i,
    input  logic [7:0]        data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic [3:0]        opcode_i,
    output logic              cpu_reset_o,
    output logic              cpu_clk_en_o,
    output logic              halted_o,
    output logic [7:0]        instr_cnt_o,
`ifdef SAP1_STEP_EN
    input  logic              step_mode_i,
    input  logic              step_i,
`endif
    output logic [ST_W-1:0]   dbg_state_o
);

    // Handshake: a byte transfers on a rising clk_i edge where valid_i && ready_o.
    // ready_o depends only on registered state, never on valid_i.

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_wr;
    logic              r_start_cnt;
    logic [7:0]        r_icnt;

    logic              w_load_req;
    logic              w_accept;
    logic              w_last;
    logic              w_run;
    logic              w_clr;
    logic              w_wrap;
    logic              w_hlt;
    logic [TCNT_W-1:0] w_tcnt;

    assign w_load_req = load_start_i && (r_state == ST_IDLE || r_state == ST_HALT);
    assign w_accept   = valid_i && (r_state == ST_LOAD);
    assign w_last     = w_accept && (r_ptr == ADDR_W'(DEPTH - 1));
    assign w_run      = (r_state == ST_RUN);
    assign w_clr      = !w_run;
    assign w_hlt      = w_run && (w_tcnt == TCNT_W'(HLT_TCNT)) && (opcode_i == OP_HLT);

    sap1_tstate_ctr #(
        .T_STATES (T_STATES),
        .CNT_W    (TCNT_W)
    ) u_tstate (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_run),
        .clr_i   (w_clr),
        .tcnt_o  (w_tcnt),
        .wrap_o  (w_wrap)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (w_load_req) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_last) w_next = ST_START;
            end
            ST_START: begin
                if (r_start_cnt) w_next = ST_RUN;
            end
            ST_RUN: begin
                // HLT is decoded mid-instruction, so it wins over any pause at the wrap
                if (w_hlt) begin
                    w_next = ST_HALT;
`ifdef SAP1_STEP_EN
                end else if (w_wrap && step_mode_i) begin
                    w_next = ST_PAUSE;
`endif
                end
            end
`ifdef SAP1_STEP_EN
            ST_PAUSE: begin
                if (step_i || !step_mode_i) w_next = ST_RUN;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_start_cnt <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_start_cnt <= (r_state == ST_START) ? !r_start_cnt : 1'b0;
        end
    end

    // RAM write port is one cycle behind the accept; pointer restarts on every load
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr  <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_wr   <= 1'b0;
        end else begin
            r_wr <= w_accept;
            if (w_load_req) begin
                r_ptr <= '0;
            end else if (w_accept) begin
                r_ptr  <= r_ptr + ADDR_W'(1);
                r_addr <= r_ptr;
                r_data <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_icnt <= 8'd0;
        end else if (w_load_req) begin
            r_icnt <= 8'd0;
        end else if (w_wrap) begin
            r_icnt <= sat_inc8(r_icnt);
        end
    end

    assign ready_o      = (r_state == ST_LOAD);
    assign mem_wr_o     = r_wr;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = r_data;
    assign cpu_reset_o  = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_START);
    assign cpu_clk_en_o = w_run;
    assign halted_o     = (r_state == ST_HALT);
    assign instr_cnt_o  = r_icnt;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_sap1_run_ctrl.sv
// Directed bench for sap1_run_ctrl; builds with or without SAP1_STEP_EN.
module tb_sap1_run_ctrl;
    import sap1_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       load_start_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       mem_wr_o;
    logic [3:0] mem_addr_o;
    logic [7:0] mem_data_o;
    logic [3:0] opcode_i;
    logic       cpu_reset_o;
    logic       cpu_clk_en_o;
    logic       halted_o;
    logic [7:0] instr_cnt_o;
    logic [2:0] dbg_state_o;
`ifdef SAP1_STEP_EN
    logic       step_mode_i;
    logic       step_i;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int wr_seen = 0;
    logic [11:0] exp_q[$];

    sap1_run_ctrl #(.DEPTH(16)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_start_i (load_start_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .mem_wr_o     (mem_wr_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .opcode_i     (opcode_i),
        .cpu_reset_o  (cpu_reset_o),
        .cpu_clk_en_o (cpu_clk_en_o),
        .halted_o     (halted_o),
        .instr_cnt_o  (instr_cnt_o),
`ifdef SAP1_STEP_EN
        .step_mode_i  (step_mode_i),
        .step_i       (step_i),
`endif
        .dbg_state_o  (dbg_state_o)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_load();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
    endtask

    // scoreboard: every RAM write must match the head of exp_q
    always @(negedge clk_i) begin
        if (mem_wr_o) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {31'd0, mem_wr_o}, 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("wr_addr_data", {20'd0, mem_addr_o, mem_data_o}, {20'd0, e});
            end
        end
    end

    initial begin
        int sent;
        int cyc;
        logic [3:0] ops [0:3];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_OUT; ops[3] = OP_HLT;
        reset_i = 1'b1; load_start_i = 1'b0; data_i = 8'h00; valid_i = 1'b0;
        opcode_i = OP_LDA;
`ifdef SAP1_STEP_EN
        step_mode_i = 1'b0; step_i = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_outs", {27'd0, ready_o, mem_wr_o, cpu_reset_o, cpu_clk_en_o, halted_o}, 32'b00100);
        chk("rst_addr", {28'd0, mem_addr_o}, 32'd0);
        chk("rst_data", {24'd0, mem_data_o}, 32'd0);
        chk("rst_icnt", {24'd0, instr_cnt_o}, 32'd0);
        chk("rst_state", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
        reset_i = 1'b0;

        // idle: stray valid bytes are ignored
        valid_i = 1'b1; data_i = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outs", {27'd0, ready_o, mem_wr_o, cpu_reset_o, cpu_clk_en_o, halted_o}, 32'b00100);
        end
        valid_i = 1'b0;

        // back-to-back load of 00..0F
        pulse_load();
        chk("ready_rise", {31'd0, ready_o}, 32'd1);
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(i)});
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_i = 8'(i);
            tick();
            chk("wr_consec", {31'd0, mem_wr_o}, 32'd1);
        end
        valid_i = 1'b0;
        chk("ready_drop", {31'd0, ready_o}, 32'd0);
        chk("start_c1", {30'd0, cpu_reset_o, cpu_clk_en_o}, 32'b10);
        tick();
        chk("start_c2", {30'd0, cpu_reset_o, cpu_clk_en_o}, 32'b10);
        tick();
        chk("run_entry", {30'd0, cpu_reset_o, cpu_clk_en_o}, 32'b01);

        // three instructions, HLT at tcnt==3 of the fourth; HLT at other T-states ignored
        for (int c = 0; c < 22; c++) begin
            if (c % 6 == 3) opcode_i = ops[c / 6];
            else if (c % 6 == 2) opcode_i = OP_HLT;
            else opcode_i = OP_LDA;
            chk("run_cyc", {30'd0, halted_o, cpu_clk_en_o}, 32'b01);
            if (c == 6) chk("icnt_first", {24'd0, instr_cnt_o}, 32'd1);
            tick();
        end
        opcode_i = OP_LDA;
        chk("halt_at_22", {29'd0, halted_o, cpu_clk_en_o, cpu_reset_o}, 32'b100);
        chk("icnt_halt", {24'd0, instr_cnt_o}, 32'd3);
        valid_i = 1'b1; data_i = 8'h55;
        repeat (3) tick();
        chk("halt_hold", {31'd0, halted_o}, 32'd1);
        valid_i = 1'b0;
        pulse_load();
        chk("reload_ready", {31'd0, ready_o}, 32'd1);
        chk("reload_icnt", {24'd0, instr_cnt_o}, 32'd0);
        chk("reload_halt", {31'd0, halted_o}, 32'd0);

        // gapped load: valid every other cycle
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), 8'(8'h40 + k)});
        sent = 0; cyc = 0;
        while (sent < 16 && cyc < 80) begin
            valid_i = (cyc % 2 == 0);
            data_i = 8'(8'h40 + sent);
            if (valid_i) chk("gap_ready", {31'd0, ready_o}, 32'd1);
            tick();
            if (valid_i) sent++;
            cyc++;
        end
        valid_i = 1'b0;
        chk("gap_sent", sent, 32'd16);
        tick();
        chk("gap_q_empty", exp_q.size(), 32'd0);
        chk("gap_wr_total", wr_seen, 32'd32);

        // reset after the 5th byte, then reload from address 0
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        chk("rst_run_state", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
        pulse_load();
        for (int k = 0; k < 5; k++) exp_q.push_back({4'(k), 8'(8'hA0 + k)});
        valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_i = 8'(8'hA0 + k);
            tick();
        end
        valid_i = 1'b0;
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        chk("rst_mid_state", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
        chk("rst_mid_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_mid_wr", {31'd0, mem_wr_o}, 32'd0);
        pulse_load();
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), 8'(8'h10 + k)});
        valid_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            data_i = 8'(8'h10 + k);
            tick();
            if (k == 0) chk("reload_addr0", {28'd0, mem_addr_o}, 32'd0);
        end
        valid_i = 1'b0;
        tick(); tick();
        chk("run2_entry", {31'd0, cpu_clk_en_o}, 32'd1);

`ifdef SAP1_STEP_EN
        begin
            int w;
            int en_cnt;
            logic [7:0] n0;
            step_mode_i = 1'b1;
            w = 0;
            while (cpu_clk_en_o && w < 20) begin
                tick();
                w++;
            end
            chk("pause_entered", {29'd0, dbg_state_o}, {29'd0, ST_PAUSE});
            n0 = instr_cnt_o;
            step_i = 1'b1; tick(); step_i = 1'b0;
            en_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                if (cpu_clk_en_o) en_cnt++;
                tick();
            end
            chk("step_en_cycles", en_cnt, 32'd6);
            chk("step_icnt", {24'd0, instr_cnt_o}, {24'd0, n0 + 8'd1});
            step_mode_i = 1'b0;
            tick(); tick();
            chk("step_resume", {31'd0, cpu_clk_en_o}, 32'd1);
        end
`endif

        // saturation of the instruction counter
        repeat (260 * 6) tick();
        chk("icnt_sat", {24'd0, instr_cnt_o}, 32'd255);
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
